// File: rtl/dct_pkg.sv
// Shared constants and FSM state encoding for the 8x8 DCT transpose controller.
package dct_pkg;
  localparam int DCT_N    = 8;
  localparam int DCT_LOGN = 3;
  localparam int DCT_DW   = 12;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } dct_state_t;
endpackage

// File: rtl/dct_onehot_dec.sv
// LOGN->N one-hot decoder with enable; all-zero output when disabled.
module dct_onehot_dec #(
  parameter int N    = 8,
  parameter int LOGN = 3
) (
  input  logic            en,
  input  logic [LOGN-1:0] idx,
  output logic [N-1:0]    onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/dct_transpose_ctrl.sv
// Fills an NxN array row-major, then drains it column-major with a 1-cycle registered read.
// Input is blocked for the whole drain; output stalls freeze the read sequence.
module dct_transpose_ctrl
  import dct_pkg::*;
#(
  parameter int DW   = DCT_DW,
  parameter int N    = DCT_N,
  parameter int LOGN = DCT_LOGN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_last,
  output logic [N-1:0]  mem_row_sel,
  output logic [N-1:0]  mem_col_sel,
  output logic          mem_read_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  dct_state_t      state;
  logic [LOGN-1:0] r;
  logic [LOGN-1:0] c;
  logic            rd_done;
  logic            accept;
  logic            issue;
  logic            sel_en;
  logic            corner;

  // in_ready is only ever high in FILL, so accept alone identifies a write.
  assign accept      = in_valid & in_ready;
  assign issue       = (state == DRAIN) & ~rd_done & (~out_valid | out_ready);
  assign sel_en      = accept | issue;
  assign corner      = (r == LAST) && (c == LAST);
  assign mem_read_wr = ~accept;
  assign mem_wdata   = in_data;

  dct_onehot_dec #(.N(N), .LOGN(LOGN)) u_row_dec (
    .en     (sel_en),
    .idx    (r),
    .onehot (mem_row_sel)
  );

  dct_onehot_dec #(.N(N), .LOGN(LOGN)) u_col_dec (
    .en     (sel_en),
    .idx    (c),
    .onehot (mem_col_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      rd_done   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
        FILL: begin
          if (accept) begin
            busy <= 1'b1;
            c    <= c + 1'b1;
            if (c == LAST) r <= r + 1'b1;
            if (corner) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              r        <= '0;
              c        <= '0;
              rd_done  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            out_last  <= corner;
            r         <= r + 1'b1;
            if (r == LAST) c <= c + 1'b1;
            if (corner) rd_done <= 1'b1;
          end else if (out_valid && out_ready) begin
            // Only reachable with reads exhausted, i.e. the last word leaving.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state    <= FILL;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              r        <= '0;
              c        <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Scoreboard bench: behavioural cell array, transposed expectations queued at stimulus time.
module tb_dct_transpose_ctrl;
  import dct_pkg::*;

  localparam int DW = DCT_DW;
  localparam int N  = DCT_N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [N-1:0]  mem_row_sel;
  logic [N-1:0]  mem_col_sel;
  logic          mem_read_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  dct_transpose_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .mem_row_sel (mem_row_sel),
    .mem_col_sel (mem_col_sel),
    .mem_read_wr (mem_read_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  // Behavioural cell array driven by the one-hot selects.
  logic [DW-1:0] mem [N][N];

  function automatic int oh2i(input logic [N-1:0] v);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) if (v[i]) k = i;
    return k;
  endfunction

  always_comb begin
    mem_rdata = '0;
    if (|mem_row_sel && |mem_col_sel) mem_rdata = mem[oh2i(mem_row_sel)][oh2i(mem_col_sel)];
  end

  always @(posedge clk)
    if (|mem_row_sel && |mem_col_sel && !mem_read_wr)
      mem[oh2i(mem_row_sel)][oh2i(mem_col_sel)] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [DW:0] q[$];
  int          wr_pos, rd_pos, out_pos, blocks_out, lat;
  bit          draining, seen_first, prev_stall, after_last;
  logic [DW:0] stall_dat;
  logic [DW:0] e;

  // Monitor samples mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      wr_pos = 0; rd_pos = 0; out_pos = 0; blocks_out = 0; lat = 0;
      draining = 0; seen_first = 0; prev_stall = 0; after_last = 0;
    end else begin
      chk("busy", busy, (wr_pos > 0) || draining);
      if (draining) chk("rdy_in_drain", in_ready, 0);
      if (after_last) begin
        chk("post_last_vld", out_valid, 0);
        chk("post_last_rdy", in_ready, 1);
        after_last = 0;
      end
      if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, stall_dat});
      if (draining && !seen_first) begin
        lat++;
        if (out_valid) begin
          chk("first_lat", lat, 2);
          seen_first = 1;
        end
      end
      if (|mem_row_sel || |mem_col_sel) begin
        chk("row_onehot", $onehot(mem_row_sel), 1);
        chk("col_onehot", $onehot(mem_col_sel), 1);
      end
      if (out_valid && !out_ready) chk("stall_sel", {mem_row_sel, mem_col_sel}, 0);
      if (!draining && !in_valid) chk("idle_sel", {mem_row_sel, mem_col_sel}, 0);
      if (|mem_row_sel && !mem_read_wr) begin
        chk("wr_in_drain", draining, 0);
        chk("wr_row", mem_row_sel, 32'd1 << (wr_pos / N));
        chk("wr_col", mem_col_sel, 32'd1 << (wr_pos % N));
        chk("wr_data", mem_wdata, in_data);
        wr_pos++;
        if (wr_pos == N*N) begin
          wr_pos = 0; draining = 1; lat = 0; seen_first = 0;
        end
      end else if (|mem_row_sel && mem_read_wr) begin
        chk("rd_in_fill", draining, 1);
        chk("rd_row", mem_row_sel, 32'd1 << (rd_pos % N));
        chk("rd_col", mem_col_sel, 32'd1 << (rd_pos / N));
        rd_pos++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("q_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_word", {out_last, out_data}, e);
        end
        out_pos++;
        if (out_last) begin
          blocks_out++;
          out_pos = 0; rd_pos = 0; draining = 0; after_last = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      stall_dat  = {out_last, out_data};
    end
  end

  task automatic send_block(input int base, input bit rnd, input bit gap, input int stop_at);
    logic [DW-1:0] v [N*N];
    bit acc;
    int wt;
    for (int i = 0; i < N*N; i++) v[i] = rnd ? DW'($urandom) : DW'(base + i);
    for (int cc = 0; cc < N; cc++)
      for (int rr = 0; rr < N; rr++)
        q.push_back({(rr == N-1) && (cc == N-1), v[rr*N + cc]});
    for (int i = 0; i < stop_at; i++) begin
      in_data  = v[i];
      in_valid = 1'b1;
      acc = 0;
      wt  = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        wt++;
        if (wt > 400) begin
          chk("in_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
      if (gap && i != N*N-1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int target, input bit bp);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    out_ready = 1'b1;
    while (blocks_out < target) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bp && !done && out_valid && out_pos == 10) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        done = 1;
      end
      if (cyc > 400) begin
        chk("drain_timeout", blocks_out, target);
        return;
      end
    end
    if (bp) chk("bp_applied", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", {mem_row_sel, mem_col_sel}, 0);
    chk("rst_read_wr", mem_read_wr, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_sel", {mem_row_sel, mem_col_sel}, 0);

    send_block(0, 0, 0, N*N);        // line rate, values 0..63
    drain(1, 0);
    send_block(64, 0, 0, N*N);       // back-pressure mid-drain
    drain(2, 1);
    send_block(0, 1, 1, N*N);        // random data, input gaps
    drain(3, 0);
    send_block(1000, 0, 0, N*N);     // in_valid held across two blocks
    send_block(2000, 0, 0, N*N);
    drain(5, 0);

    send_block(300, 0, 0, 20);       // abort mid-fill
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sel", {mem_row_sel, mem_col_sel}, 0);
    chk("arst_read_wr", mem_read_wr, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_rdy", in_ready, 1);
    send_block(0, 1, 0, N*N);
    drain(1, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
